// File: rtl/cim_weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : cim_weight_loader
// Purpose  : Write-side controller for the dual-bank CIM weight array.
//            Takes a load command (bank mask, start row, word count) and a
//            stream of weight words, and turns each word into a
//            setup / one-cycle write pulse / hold sequence on the shared
//            data bus D and the per-bank one-hot row enables WA0/WA1.
// Revision : 1.0 - initial release
// ============================================================================
module cim_weight_loader #(
  parameter int DW   = 24,
  parameter int ROWS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  // load command
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_bank,
  input  logic [2:0]      cmd_row,
  input  logic [3:0]      cmd_len,
  // weight word stream
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  // cancel of the load in progress
  input  logic            abort,
  // array write port
  output logic [DW-1:0]   D,
  output logic [ROWS-1:0] WA0,
  output logic [ROWS-1:0] WA1,
  // status
  output logic            busy,
  output logic            done
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_WAIT  = 3'd1;
  localparam logic [2:0] c_SETUP = 3'd2;
  localparam logic [2:0] c_PULSE = 3'd3;
  localparam logic [2:0] c_HOLD  = 3'd4;

  // A single load never writes more words than there are rows in a bank.
  localparam logic [3:0] c_MAX_LEN  = 4'd8;
  localparam logic [2:0] c_LAST_ROW = 3'(ROWS - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]                r_state;
  logic [1:0]                r_bank;
  logic [2:0]                r_row;
  logic [3:0]                r_count;
  logic [DW-1:0]             r_data;
  logic [1:0][ROWS-1:0]      r_wa;
  logic                      r_done;
  // Low while in reset and until the first clock edge after release, so
  // cmd_ready is held off even though the state already reads IDLE.
  logic                      r_live;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [2:0]                w_state_next;
  logic                      w_cmd_fire;
  logic                      w_in_fire;
  logic [3:0]                w_len_clamped;
  logic                      w_noop;
  logic                      w_start_pulse;
  logic                      w_finish;
  logic [ROWS-1:0]           w_onehot;
  logic [1:0][ROWS-1:0]      w_wa_next;

  assign cmd_ready     = r_live && (r_state == c_IDLE);
  assign in_ready      = (r_state == c_WAIT);
  assign busy          = (r_state != c_IDLE);

  assign w_cmd_fire    = cmd_valid && cmd_ready;
  assign w_in_fire     = in_valid && in_ready;

  assign w_len_clamped = (cmd_len > c_MAX_LEN) ? c_MAX_LEN : cmd_len;
  // An empty load or an empty bank mask completes without touching the array.
  assign w_noop        = (w_len_clamped == 4'd0) || (cmd_bank == 2'b00);

  // The write pulse is launched from SETUP unless the load is being cancelled,
  // which is how a word already accepted but not yet pulsed gets dropped.
  assign w_start_pulse = (r_state == c_SETUP) && !abort;

  // Last word of the load leaves HOLD normally; an abort suppresses done.
  assign w_finish      = (r_state == c_HOLD) && !abort && (r_count <= 4'd1);

  assign w_onehot      = ROWS'(1) << r_row;

  // Per-bank enable: one-hot row only for banks selected in the mask.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_wa_next[b] = (w_start_pulse && r_bank[b]) ? w_onehot : '0;
  end

  // Next-state logic; abort returns any active state straight to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_cmd_fire && !w_noop) begin
          w_state_next = c_WAIT;
        end
      end
      c_WAIT: begin
        if (abort) begin
          w_state_next = c_IDLE;
        end else if (w_in_fire) begin
          w_state_next = c_SETUP;
        end
      end
      c_SETUP: begin
        w_state_next = abort ? c_IDLE : c_PULSE;
      end
      c_PULSE: begin
        w_state_next = abort ? c_IDLE : c_HOLD;
      end
      c_HOLD: begin
        if (abort || (r_count <= 4'd1)) begin
          w_state_next = c_IDLE;
        end else begin
          w_state_next = c_WAIT;
        end
      end
      default: begin
        w_state_next = c_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Marks the controller usable from the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // Load context: bank mask, row pointer and remaining word count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank  <= 2'b00;
      r_row   <= 3'd0;
      r_count <= 4'd0;
    end else if (w_cmd_fire) begin
      r_bank  <= cmd_bank;
      r_row   <= cmd_row;
      r_count <= w_len_clamped;
    end else if ((r_state == c_HOLD) && !abort) begin
      r_row   <= (r_row == c_LAST_ROW) ? 3'd0 : (r_row + 3'd1);
      r_count <= r_count - 4'd1;
    end
  end

  // Data bus: captures a word only when it is accepted for writing, and
  // otherwise keeps the last written word on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_in_fire && !abort) begin
      r_data <= in_data;
    end
  end

  // Row enables: high for exactly the PULSE cycle, zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wa <= '0;
    end else begin
      r_wa <= w_wa_next;
    end
  end

  // Completion pulse, for both real loads and no-op commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_cmd_fire && w_noop) || w_finish;
    end
  end

  assign D    = r_data;
  assign WA0  = r_wa[0];
  assign WA1  = r_wa[1];
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cim_weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cim_weight_loader
// Purpose  : Directed self-checking bench for cim_weight_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cim_weight_loader;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_bank;
  logic [2:0]  cmd_row;
  logic [3:0]  cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        abort;
  logic [23:0] D;
  logic [7:0]  WA0;
  logic [7:0]  WA1;
  logic        busy;
  logic        done;

  cim_weight_loader #(.DW(24), .ROWS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_bank  (cmd_bank),
    .cmd_row   (cmd_row),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .D         (D),
    .WA0       (WA0),
    .WA1       (WA1),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // stimulus settings for run_load
  logic [23:0] words [16];
  int          nwords;
  int          stall_word;
  int          stall_len;
  int          abort_word;

  // per-cycle history, index = cycles after command accept
  logic [23:0] d_hist    [64];
  logic [7:0]  wa0_hist  [64];
  logic [7:0]  wa1_hist  [64];
  logic        busy_hist [64];
  logic        done_hist [64];

  int          p_cyc [$];
  logic [7:0]  p_wa0 [$];
  logic [7:0]  p_wa1 [$];
  logic [23:0] p_d   [$];
  int          done_cyc;
  int          accepted;
  int          saw_in_ready;
  int          both_rdy = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, then drive the word stream and record every cycle.
  task automatic run_load(input logic [1:0] bank, input logic [2:0] row,
                          input logic [3:0] len, input int budget);
    int widx;
    int stall_cnt;
    int setup_idx;
    int next_setup;
    p_cyc.delete(); p_wa0.delete(); p_wa1.delete(); p_d.delete();
    done_cyc     = -1;
    accepted     = 0;
    saw_in_ready = 0;
    check("cmd_ready before cmd", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_bank  = bank;
    cmd_row   = row;
    cmd_len   = len;
    step();
    cmd_valid  = 1'b0;
    widx       = 0;
    stall_cnt  = 0;
    next_setup = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      d_hist[cyc]    = D;
      wa0_hist[cyc]  = WA0;
      wa1_hist[cyc]  = WA1;
      busy_hist[cyc] = busy;
      done_hist[cyc] = done;
      if ((WA0 | WA1) != 8'h00) begin
        p_cyc.push_back(cyc);
        p_wa0.push_back(WA0);
        p_wa1.push_back(WA1);
        p_d.push_back(D);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (cmd_ready && in_ready) both_rdy++;
      if (in_ready) saw_in_ready++;
      setup_idx  = next_setup;
      next_setup = -1;
      abort = (abort_word >= 0) && (setup_idx == abort_word);
      if (widx == stall_word && stall_cnt < stall_len) begin
        in_valid = 1'b0;
        if (in_ready) stall_cnt++;
      end else begin
        in_valid = (widx < nwords);
        if (widx < nwords) in_data = words[widx];
      end
      if (in_valid && in_ready) begin
        next_setup = widx;
        widx++;
        accepted++;
      end
      step();
    end
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  // Compare recorded pulse i with the expected one, plus D stability around it.
  task automatic expect_pulse(input string tag, input int i, input int cyc,
                              input logic [7:0] wa0, input logic [7:0] wa1,
                              input logic [23:0] d);
    check({tag, " present"}, 32'(p_cyc.size() > i), 1);
    if (p_cyc.size() > i) begin
      check({tag, " cycle"}, p_cyc[i], cyc);
      check({tag, " WA0"}, 32'(p_wa0[i]), 32'(wa0));
      check({tag, " WA1"}, 32'(p_wa1[i]), 32'(wa1));
      check({tag, " D"}, 32'(p_d[i]), 32'(d));
      check({tag, " D before"}, 32'(d_hist[cyc-1]), 32'(d));
      check({tag, " D after"}, 32'(d_hist[cyc+1]), 32'(d));
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_bank = 2'b00; cmd_row = 3'd0;
    cmd_len = 4'd0; in_valid = 1'b0; in_data = 24'h0; abort = 1'b0;
    stall_word = -1; stall_len = 0; abort_word = -1; nwords = 0;
    step(); step();
    check("rst cmd_ready", 32'(cmd_ready), 0);
    check("rst in_ready", 32'(in_ready), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst D", 32'(D), 0);
    check("rst WA", 32'({WA1, WA0}), 0);
    rst_n = 1'b1;
    step();
    check("post-rst cmd_ready", 32'(cmd_ready), 1);

    // T1: bank0, rows 0..7, back-to-back words
    for (int i = 0; i < 8; i++) words[i] = 24'(i + 1);
    nwords = 8;
    run_load(2'b01, 3'd0, 4'd8, 40);
    check("t1 pulses", p_cyc.size(), 8);
    for (int i = 0; i < 8; i++)
      expect_pulse($sformatf("t1 p%0d", i), i, 3 + 4 * i, 8'(1 << i), 8'h00, 24'(i + 1));
    check("t1 done cycle", done_cyc, 33);
    check("t1 done width", 32'(done_hist[34]), 0);

    // T2: both banks, row wrap 6,7,0
    words[0] = 24'hAAAAAA; words[1] = 24'h555555; words[2] = 24'hFFFFFF;
    nwords = 3;
    run_load(2'b11, 3'd6, 4'd3, 16);
    check("t2 pulses", p_cyc.size(), 3);
    expect_pulse("t2 p0", 0, 3,  8'h40, 8'h40, 24'hAAAAAA);
    expect_pulse("t2 p1", 1, 7,  8'h80, 8'h80, 24'h555555);
    expect_pulse("t2 p2", 2, 11, 8'h01, 8'h01, 24'hFFFFFF);
    check("t2 done cycle", done_cyc, 13);

    // T3: zero length, then empty mask
    nwords = 4;
    run_load(2'b01, 3'd2, 4'd0, 3);
    check("t3a done cycle", done_cyc, 1);
    check("t3a busy", 32'(busy_hist[1]), 0);
    check("t3a done width", 32'(done_hist[2]), 0);
    check("t3a in_ready", saw_in_ready, 0);
    check("t3a pulses", p_cyc.size(), 0);
    run_load(2'b00, 3'd2, 4'd4, 3);
    check("t3b done cycle", done_cyc, 1);
    check("t3b in_ready", saw_in_ready, 0);
    check("t3b pulses", p_cyc.size(), 0);

    // T4: length 12 clamps to 8; a ninth word is offered but not taken
    for (int i = 0; i < 9; i++) words[i] = 24'h000100 + 24'(i);
    nwords = 9;
    run_load(2'b10, 3'd0, 4'd12, 40);
    check("t4 accepted", accepted, 8);
    check("t4 pulses", p_cyc.size(), 8);
    expect_pulse("t4 p0", 0, 3,  8'h00, 8'h01, 24'h000100);
    expect_pulse("t4 p7", 7, 31, 8'h00, 8'h80, 24'h000107);
    check("t4 done cycle", done_cyc, 33);

    // T5: 10-cycle input stall before the third word
    for (int i = 0; i < 4; i++) words[i] = 24'h0A0000 + 24'(i);
    nwords = 4; stall_word = 2; stall_len = 10;
    run_load(2'b01, 3'd3, 4'd4, 32);
    stall_word = -1;
    begin
      logic [7:0] wa_or;
      wa_or = 8'h00;
      for (int c = 9; c <= 20; c++) wa_or = wa_or | wa0_hist[c] | wa1_hist[c];
      check("t5 WA during stall", 32'(wa_or), 0);
    end
    check("t5 pulses", p_cyc.size(), 4);
    expect_pulse("t5 p1", 1, 7,  8'h10, 8'h00, 24'h0A0001);
    expect_pulse("t5 p2", 2, 21, 8'h20, 8'h00, 24'h0A0002);
    expect_pulse("t5 p3", 3, 25, 8'h40, 8'h00, 24'h0A0003);
    check("t5 done cycle", done_cyc, 27);

    // T6: abort in SETUP of the third word
    for (int i = 0; i < 5; i++) words[i] = 24'h0B0000 + 24'(i);
    nwords = 5; abort_word = 2;
    run_load(2'b01, 3'd0, 4'd5, 20);
    abort_word = -1;
    check("t6 pulses", p_cyc.size(), 2);
    check("t6 busy in SETUP", 32'(busy_hist[10]), 1);
    check("t6 busy after abort", 32'(busy_hist[11]), 0);
    check("t6 WA after abort", 32'({wa1_hist[11], wa0_hist[11]}), 0);
    check("t6 no done", done_cyc, -1);
    check("t6 accepted", accepted, 3);
    check("t6 cmd_ready", 32'(cmd_ready), 1);

    // T7: reset asserted during PULSE clears WA without a clock edge
    cmd_valid = 1'b1; cmd_bank = 2'b01; cmd_row = 3'd2; cmd_len = 4'd2;
    step();
    cmd_valid = 1'b0; in_valid = 1'b1; in_data = 24'h123456;
    step();
    in_valid = 1'b0;
    check("t7 D in SETUP", 32'(D), 32'h123456);
    step();
    check("t7 WA0 in PULSE", 32'(WA0), 32'h04);
    #2 rst_n = 1'b0;
    #1;
    check("t7 WA0 async rst", 32'(WA0), 0);
    check("t7 WA1 async rst", 32'(WA1), 0);
    check("t7 busy async rst", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    step();
    check("t7 cmd_ready after rst", 32'(cmd_ready), 1);
    check("t7 busy after rst", 32'(busy), 0);

    check("ready overlap", both_rdy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cim_weight_loader.md
# cim_weight_loader

Write-side controller for the dual-bank CIM weight array. It accepts a load command and a stream of 24-bit weight words, and converts each word into a safe write sequence on the array's shared data bus `D` and its per-bank one-hot row enables `WA0`/`WA1`. The sequence is setup, then a one-cycle write pulse, then hold. It sits between the weight DMA/host interface and the CIM array, and is the only block that drives the array write port.

## Interface
- `DW`, 24: weight word width; must equal the array `D` width.
- `ROWS`, 8: rows per bank; width of `WA0`/`WA1`.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: load command valid.
- `cmd_ready` output 1: command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_bank` input 2: bank mask. Bit0 selects bank0 (`WA0`), bit1 selects bank1 (`WA1`); both bits set writes both banks.
- `cmd_row` input 3: start row.
- `cmd_len` input 4: number of words, 0..15. Values above 8 clamp to 8.
- `in_valid` input 1: weight word valid.
- `in_ready` output 1: word accepted when both `in_valid` and `in_ready` are high.
- `in_data` input DW: weight word.
- `abort` input 1: synchronous cancel of the current load.
- `D` output DW: array write data; registered.
- `WA0` output ROWS: bank0 one-hot row write enable; registered. All-zero means no write.
- `WA1` output ROWS: bank1 one-hot row write enable; registered.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse when a load completes or is treated as a no-op.

## Operation
- States are IDLE, WAIT, SETUP, PULSE, HOLD.
- IDLE:
  - `cmd_ready` is 1.
  - On command accept, latch the bank mask, row pointer = `cmd_row`, and remaining count = min(`cmd_len`, 8).
  - If the count is 0 or the mask is 00, stay in IDLE, pulse `done` next cycle, and issue no writes.
  - Otherwise go to WAIT.
- WAIT:
  - `in_ready` is 1.
  - On word accept, register `in_data` into `D` and go to SETUP.
- SETUP: `D` shows the new word; `WA0`/`WA1` are zero; go to PULSE.
- PULSE:
  - `WA0` = one-hot(row) if mask bit0 is set, else zero. `WA1` likewise for mask bit1. `D` is unchanged.
  - Go to HOLD.
- HOLD:
  - WA outputs return to zero; `D` is held.
  - Row pointer advances by 1 modulo 8 (row 7 wraps to row 0); count decrements.
  - If the count reaches 0, go to IDLE and assert `done`; otherwise go to WAIT.
- Between writes, `D` keeps the last written word. It changes only on a word accept.
- At most one bit of each WA bus is ever high, and only in PULSE.
- `abort`, when sampled high in any non-IDLE state:
  - The next state is IDLE and WA outputs are zero from the next cycle.
  - Remaining words are not requested; `done` is not asserted.
  - A word already accepted but not yet pulsed is dropped.
- `abort` in IDLE is ignored. `abort` has priority over a same-cycle word accept: the word is still consumed from the stream but is not written.
- Reset: asynchronous. `D`=0, `WA0`=`WA1`=0, `busy`=0, `done`=0, `in_ready`=0, `cmd_ready`=0. The state goes to IDLE, so `cmd_ready` reads 1 from the first edge after reset release. Reset mid-PULSE drops the WA outputs immediately, without waiting for a clock edge.

## Timing
- Command accepted at edge c: WAIT from cycle c+1; `in_ready` is 1 in that cycle.
- Word accepted at edge k:
  - Cycle k+1: SETUP, `D` = word.
  - Cycle k+2: PULSE.
  - Cycle k+3: HOLD.
  - Cycle k+4: WAIT, or IDLE with `done` = 1 and `cmd_ready` = 1.
- Throughput: minimum 4 cycles per word. An 8-word load takes 33 cycles from command accept to `done` when input is always valid.
- `cmd_ready` and `in_ready` are never high in the same cycle.
- A new command can be accepted in the same cycle that `done` is high.

## Test plan
- Reset, then command bank=01, row=0, len=8, with words 0x000001..0x000008 streamed back-to-back -> `WA0` pulses 0x01, 0x02, ... 0x80 at 4-cycle spacing with matching `D`; `WA1` stays 0; `done` 33 cycles after command accept.
- Command bank=11, row=6, len=3, words 0xAAAAAA, 0x555555, 0xFFFFFF -> both WA buses pulse 0x40, then 0x80, then 0x01 (wrap); `D` is stable one cycle before and one cycle after each pulse.
- Command len=0, then bank=00 with len=4 -> no WA activity and no `in_ready`; `done` one cycle after each accept.
- Command len=12 -> exactly 8 words requested; the ninth `in_valid` is not accepted.
- Stall `in_valid` low for 10 cycles mid-load -> WA stays 0 throughout the stall; the next pulse lands on the correct next row.
- Assert `abort` during SETUP of word 3 -> no third pulse; `busy` low next cycle; no `done`. Then assert `rst_n` low during a PULSE of a new load -> WA0/WA1 drop to 0 immediately; `cmd_ready` is 1 after release.
